mul_div_unit: RTL

- Multi-cycle iterative multiply/divide unit. It sits directly downstream of reg_file.
- Operand A comes from rdata1 and operand B from rdata2.
- It implements the MIPS MULT/MULTU/DIV/DIVU instructions into private HI/LO registers. MTHI/MTLO writes also land in HI/LO.
- Control issues an operation with a start pulse, stalls on busy, and reads hi/lo for MFHI/MFLO.

---
 rtl/mdu_pkg.sv | 35 +++
 rtl/mdu_sign_fix.sv | 45 ++++
 rtl/mul_div_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings as driven on the op port (MULT, MULTU, DIV, DIVU)
//   - FSM state encoding
//   - default operand / HI / LO width
//   - small decode helpers for the op field
// The divide datapath is built only when MDU_DIV_EN is defined; the
// encodings are always present so control and the bench see one view.
package mdu_pkg;

    localparam int MDU_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    // Signed ops work on operand magnitudes and fix the sign afterwards.
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: combinational two's-complement magnitude/negate helper.
// Two lanes of WIDTH bits each. In split mode (wide=0) each lane is
// negated independently; in wide mode (wide=1) the lanes form one
// 2*WIDTH value {hi_in, lo_in} negated as a whole under neg_hi.
// Ports:
//   wide            in   1      join the lanes into one 2*WIDTH value
//   neg_hi, neg_lo  in   1      negate request per lane (neg_lo unused when wide)
//   hi_in, lo_in    in   WIDTH  lane inputs
//   hi_out, lo_out  out  WIDTH  lane outputs
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic             wide,
    input  logic             neg_hi,
    input  logic             neg_lo,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [2*WIDTH-1:0] joined;
    logic [2*WIDTH-1:0] joined_neg;
    logic [WIDTH-1:0]   hi_neg;
    logic [WIDTH-1:0]   lo_neg;

    assign joined     = {hi_in, lo_in};
    assign joined_neg = ~joined + 1'b1;
    assign hi_neg     = ~hi_in + 1'b1;
    assign lo_neg     = ~lo_in + 1'b1;

    always_comb begin
        hi_out = hi_in;
        lo_out = lo_in;
        if (wide) begin
            if (neg_hi) begin
                {hi_out, lo_out} = joined_neg;
            end
        end else begin
            if (neg_hi) hi_out = hi_neg;
            if (neg_lo) lo_out = lo_neg;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle iterative MIPS multiply/divide unit with
// private HI/LO registers (MULT, MULTU, DIV, DIVU, plus MTHI/MTLO writes).
// Build option: define MDU_DIV_EN to include the divide datapath. Without
// it, DIV/DIVU requests are rejected with a one-cycle illegal pulse and
// dbz is always 0.
// Ports:
//   clk         in   1           rising-edge clock
//   rst         in   1           synchronous active-low reset
//   start       in   1           operation request, sampled only in IDLE
//   op          in   2           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a       in   DATA_WIDTH  operand A / dividend
//   src_b       in   DATA_WIDTH  operand B / divisor
//   hilo_wen    in   2           bit1 write HI, bit0 write LO (IDLE only)
//   hilo_wdata  in   DATA_WIDTH  MTHI/MTLO data
//   busy        out  1           high in CALC, FIX and DONE
//   done        out  1           one-cycle pulse, hi/lo hold the new result
//   dbz         out  1           divide-by-zero, valid with done
//   illegal     out  1           one-cycle pulse on a rejected op
//   hi, lo      out  DATA_WIDTH  HI / LO registers
//
// Handshake: a request is taken on a rising edge where the unit is idle
// (busy=0), start=1 and hilo_wen=0. From the following cycle busy stays
// high until the cycle after done; start while busy is dropped, not
// queued. done rises for one cycle exactly DATA_WIDTH+1 edges after the
// accept edge, with hi/lo/dbz already valid in that cycle.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = MDU_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic [1:0]            hilo_wen,
    input  logic [DATA_WIDTH-1:0] hilo_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  dbz,
    output logic                  illegal,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    // FSM state, kept as a plain named register so checkers can bind to it.
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_div_r;
    logic             sign_a;
    logic             sign_b;
    // opd: multiplicand (multiply) or divisor (divide), held for the op.
    logic [W-1:0]     opd;
    // acc: multiply = {partial product high, remaining multiplier bits};
    //      divide   = {partial remainder, dividend bits / quotient bits}.
    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   acc_next;

    // ---------------- operand magnitudes ----------------
    logic         in_signed;
    logic         in_div;
    logic         accept_ok;
    logic [W-1:0] mag_a;
    logic [W-1:0] mag_b;

    assign in_signed = op_is_signed(op);
    assign in_div    = op_is_div(op);
    assign accept_ok = DIV_EN || !in_div;

    mdu_sign_fix #(.WIDTH(W)) u_abs (
        .wide   (1'b0),
        .neg_hi (in_signed & src_a[W-1]),
        .neg_lo (in_signed & src_b[W-1]),
        .hi_in  (src_a),
        .lo_in  (src_b),
        .hi_out (mag_a),
        .lo_out (mag_b)
    );

    // ---------------- iteration step ----------------
    // Shift-add multiply: add the multiplicand into the upper half when the
    // current multiplier bit (acc[0]) is set, then shift the whole
    // accumulator right, carry included.
    logic [W:0] mul_sum;
    assign mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opd} : {(W+1){1'b0}});

`ifdef MDU_DIV_EN
    logic       b_zero;
    logic [W:0] div_shift;
    logic [W:0] div_diff;
    // Restoring divide: bring the next dividend bit into the remainder,
    // trial-subtract the divisor, keep the difference if it did not borrow.
    // A zero divisor never borrows, so the quotient fills with ones and the
    // remainder ends up equal to the dividend magnitude.
    assign div_shift = {acc[2*W-1:W], acc[W-1]};
    assign div_diff  = div_shift - {1'b0, opd};
`endif

    always_comb begin
        acc_next = {mul_sum, acc[W-1:1]};
`ifdef MDU_DIV_EN
        if (is_div_r) begin
            if (div_diff[W]) acc_next = {div_shift[W-1:0], acc[W-2:0], 1'b0};
            else             acc_next = {div_diff[W-1:0],  acc[W-2:0], 1'b1};
        end
`endif
    end

    // ---------------- result sign correction ----------------
    // Multiply: negate the full product when the signs differ.
    // Divide: remainder follows the dividend sign; quotient is negated when
    // the signs differ, except on divide-by-zero where it stays all ones.
    logic         fix_neg_hi;
    logic         fix_neg_lo;
    logic [W-1:0] res_hi;
    logic [W-1:0] res_lo;

    always_comb begin
        fix_neg_hi = sign_a ^ sign_b;
        fix_neg_lo = 1'b0;
`ifdef MDU_DIV_EN
        if (is_div_r) begin
            fix_neg_hi = sign_a;
            fix_neg_lo = (sign_a ^ sign_b) & ~b_zero;
        end
`endif
    end

    mdu_sign_fix #(.WIDTH(W)) u_fix (
        .wide   (~is_div_r),
        .neg_hi (fix_neg_hi),
        .neg_lo (fix_neg_lo),
        .hi_in  (acc[2*W-1:W]),
        .lo_in  (acc[W-1:0]),
        .hi_out (res_hi),
        .lo_out (res_lo)
    );

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_div_r <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            opd      <= '0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dbz      <= 1'b0;
            illegal  <= 1'b0;
`ifdef MDU_DIV_EN
            b_zero   <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            dbz     <= 1'b0;
            illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    // An MTHI/MTLO write takes priority and drops a same-cycle start.
                    if (hilo_wen != 2'b00) begin
                        if (hilo_wen[1]) hi <= hilo_wdata;
                        if (hilo_wen[0]) lo <= hilo_wdata;
                    end else if (start) begin
                        if (!accept_ok) begin
                            illegal <= 1'b1;
                        end else begin
                            is_div_r <= in_div;
                            sign_a   <= in_signed & src_a[W-1];
                            sign_b   <= in_signed & src_b[W-1];
                            // Divide iterates over the dividend, multiply over the multiplier.
                            acc      <= {{W{1'b0}}, (in_div ? mag_a : mag_b)};
                            opd      <= in_div ? mag_b : mag_a;
                            cnt      <= '0;
                            busy     <= 1'b1;
                            state    <= S_CALC;
`ifdef MDU_DIV_EN
                            b_zero   <= (src_b == '0);
`endif
                        end
                    end
                end
                S_CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(W-1)) state <= S_FIX;
                end
                S_FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
`ifdef MDU_DIV_EN
                    dbz   <= is_div_r & b_zero;
`endif
                    state <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
